gpr_wb_arbiter: RTL and testbench

//  Shares the single GPR write port (wren/addr_c/data_in_c) between the EX and MEM writeback requesters.

---
 rtl/gpr_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the single GPR write port between the EX and MEM
// writeback stages, keeps a per-register pending-write scoreboard for read
// hazard detection, and runs a clear sequence that zeroes r1..r31.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation, EX/MEM arbitration active
// CLEAR | writing 0 to register idx each cycle, requesters stalled
// DRAIN | one settling cycle after the last clear write, still busy
module gpr_wb_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_data,
    output logic          ex_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    input  logic          claim_valid,
    input  logic [AW-1:0] claim_addr,
    output logic          claim_ready,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          hazard_a,
    output logic          hazard_b,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          gpr_wren,
    output logic [AW-1:0] gpr_addr,
    output logic [DW-1:0] gpr_data
);

    localparam int NREG = 2 ** AW;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    IDX_LAST = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rr_mem;      // 0: EX wins a tie, 1: MEM wins a tie
    logic [AW-1:0]    idx;
    logic             clr_enter;
    logic             both_valid;
    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  claim_hit;
    logic [NREG-1:0]  retire_hit;

    assign both_valid = ex_valid & mem_valid;
    assign clr_enter  = (state == ST_IDLE) & clr_start;
    assign clr_busy   = (state != ST_IDLE);

    // Next-state and grant decode; grants only happen in IDLE.
    always_comb begin
        state_nxt = state;
        ex_ready  = 1'b0;
        mem_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (both_valid) begin
                    ex_ready  = ~rr_mem;
                    mem_ready = rr_mem;
                end else begin
                    ex_ready  = ex_valid;
                    mem_ready = mem_valid;
                end
                if (clr_start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (idx == IDX_LAST) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, round-robin pointer and clear index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_mem <= 1'b0;
            idx    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && both_valid) rr_mem <= ~rr_mem;
            if (clr_enter) idx <= AW'(1);
            else if (state == ST_CLEAR) idx <= idx + AW'(1);
        end
    end

    // Registered GPR write port; writes to r0 are granted but never issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_wren <= 1'b0;
            gpr_addr <= '0;
            gpr_data <= '0;
        end else if (state == ST_CLEAR) begin
            gpr_wren <= 1'b1;
            gpr_addr <= idx;
            gpr_data <= '0;
        end else if (ex_ready) begin
            gpr_wren <= (ex_addr != '0);
            gpr_addr <= ex_addr;
            gpr_data <= ex_data;
        end else if (mem_ready) begin
            gpr_wren <= (mem_addr != '0);
            gpr_addr <= mem_addr;
            gpr_data <= mem_data;
        end else begin
            gpr_wren <= 1'b0;
        end
    end

    // One-hot claim and retire strobes per register.
    always_comb begin
        claim_hit  = '0;
        retire_hit = '0;
        if (claim_valid && claim_ready && claim_addr != '0) claim_hit[claim_addr] = 1'b1;
        if (gpr_wren) retire_hit[gpr_addr] = 1'b1;
    end

    // Scoreboard counters; a same-cycle claim and retire cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (clr_enter) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (claim_hit[r] && !retire_hit[r]) begin
                    if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (retire_hit[r] && !claim_hit[r]) begin
                    if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // A full counter may still take a claim if it retires in the same cycle.
    always_comb begin
        claim_ready = ~clr_busy & ((claim_addr == '0) ||
                                   (cnt[claim_addr] != CNT_MAX) ||
                                   (gpr_wren && gpr_addr == claim_addr));
        hazard_a    = (rd_addr_a != '0) && (cnt[rd_addr_a] != '0);
        hazard_b    = (rd_addr_b != '0) && (cnt[rd_addr_b] != '0);
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Testbench for gpr_wb_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked each cycle against a
// transaction-level model of the arbiter and scoreboard.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 0, mem_valid = 0, claim_valid = 0, clr_start = 0;
    logic [4:0]  ex_addr = 0, mem_addr = 0, claim_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
    logic [31:0] ex_data = 0, mem_data = 0;
    logic        ex_ready, mem_ready, claim_ready, hazard_a, hazard_b, clr_busy, gpr_wren;
    logic [4:0]  gpr_addr;
    logic [31:0] gpr_data;

    int total = 0;
    int bad   = 0;

    gpr_wb_arbiter #(.DW(32), .AW(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .gpr_wren(gpr_wren), .gpr_addr(gpr_addr), .gpr_data(gpr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending write, per-register pending counts, tie-break
    // owner and number of busy cycles left in the clear sequence.
    int          m_cnt [32];
    bit          m_wren;
    int          m_addr;
    logic [31:0] m_data;
    bit          m_rr_mem;
    int          m_busy_left;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_wren = 0; m_addr = 0; m_data = 0; m_rr_mem = 0; m_busy_left = 0;
    endtask

    // Compare on every falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        bit e_ex, e_mem, e_claim, c_hit, r_hit;
        int old_busy;
        if (rst) begin
            model_reset();
            chk("rst_addr", gpr_addr, 0);
            chk("rst_data", gpr_data, 0);
        end
        e_ex    = (m_busy_left == 0) && ex_valid && (!mem_valid || !m_rr_mem);
        e_mem   = (m_busy_left == 0) && mem_valid && (!ex_valid || m_rr_mem);
        e_claim = (m_busy_left == 0) && (claim_addr == 0 || m_cnt[claim_addr] < 3 ||
                                         (m_wren && m_addr == int'(claim_addr)));
        chk("ex_ready", ex_ready, e_ex);
        chk("mem_ready", mem_ready, e_mem);
        chk("claim_ready", claim_ready, e_claim);
        chk("hazard_a", hazard_a, rd_addr_a != 0 && m_cnt[rd_addr_a] != 0);
        chk("hazard_b", hazard_b, rd_addr_b != 0 && m_cnt[rd_addr_b] != 0);
        chk("clr_busy", clr_busy, m_busy_left != 0);
        chk("gpr_wren", gpr_wren, m_wren);
        if (m_wren) begin
            chk("gpr_addr", gpr_addr, m_addr);
            chk("gpr_data", gpr_data, m_data);
        end
        if (!rst) begin
            c_hit = claim_valid && e_claim && claim_addr != 0;
            r_hit = m_wren;
            if (c_hit && r_hit && int'(claim_addr) == m_addr) begin
                // claim and retire of the same register cancel
            end else begin
                if (c_hit && m_cnt[claim_addr] < 3) m_cnt[claim_addr]++;
                if (r_hit && m_cnt[m_addr] > 0) m_cnt[m_addr]--;
            end
            old_busy = m_busy_left;
            if (old_busy >= 2) begin
                m_wren = 1; m_addr = 33 - old_busy; m_data = 0;
            end else if (e_ex) begin
                m_wren = ex_addr != 0; m_addr = ex_addr; m_data = ex_data;
            end else if (e_mem) begin
                m_wren = mem_addr != 0; m_addr = mem_addr; m_data = mem_data;
            end else begin
                m_wren = 0;
            end
            if (old_busy == 0 && ex_valid && mem_valid) m_rr_mem = !m_rr_mem;
            if (old_busy == 0 && clr_start) begin
                for (int r = 0; r < 32; r++) m_cnt[r] = 0;
                m_busy_left = 32;
            end else if (old_busy > 0) begin
                m_busy_left = old_busy - 1;
            end
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_n, wr_ok, viol, nxt, granted, found;
        bit ex_go, mem_go;
        int exp_addr [4];

        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1) EX only
        ex_valid = 1; ex_addr = 3; ex_data = 32'hDEADBEEF;
        to_neg(); chk("t1_ex_ready", ex_ready, 1);
        to_next(); ex_valid = 0;
        to_neg();
        chk("t1_wren", gpr_wren, 1);
        chk("t1_addr", gpr_addr, 3);
        chk("t1_data", gpr_data, 32'hDEADBEEF);
        to_next();

        // 2) both valid, alternating grants starting with EX
        exp_addr[0] = 10; exp_addr[1] = 20; exp_addr[2] = 10; exp_addr[3] = 20;
        ex_valid = 1; ex_addr = 10; ex_data = 32'h10;
        mem_valid = 1; mem_addr = 20; mem_data = 32'h20;
        for (int i = 0; i < 4; i++) begin
            to_neg();
            chk("t2_ex_ready", ex_ready, (i % 2) == 0);
            chk("t2_mem_ready", mem_ready, (i % 2) == 1);
            if (i > 0) chk("t2_lag_addr", gpr_addr, exp_addr[i-1]);
            to_next();
        end
        ex_valid = 0; mem_valid = 0;
        to_neg(); chk("t2_last_addr", gpr_addr, exp_addr[3]);
        to_next();

        // 3) claim r7, then EX writes r7
        claim_valid = 1; claim_addr = 7; rd_addr_a = 7;
        to_neg(); chk("t3_claim_ready", claim_ready, 1); chk("t3_haz_pre", hazard_a, 0);
        to_next(); claim_valid = 0;
        to_neg(); chk("t3_haz_set", hazard_a, 1);
        to_next(); ex_valid = 1; ex_addr = 7; ex_data = 32'h77;
        to_neg(); chk("t3_ex_ready", ex_ready, 1); chk("t3_haz_grant", hazard_a, 1);
        to_next(); ex_valid = 0;
        to_neg(); chk("t3_wren", gpr_wren, 1); chk("t3_haz_retire", hazard_a, 1);
        to_next();
        to_neg(); chk("t3_haz_clear", hazard_a, 0);
        to_next();

        // 4) saturate r9 (max 3), then claim plus same-cycle retire
        claim_valid = 1; claim_addr = 9; rd_addr_b = 9;
        for (int i = 0; i < 4; i++) begin
            to_neg(); chk("t4_claim", claim_ready, i < 3);
            to_next();
        end
        claim_valid = 0; ex_valid = 1; ex_addr = 9; ex_data = 32'h9;
        to_neg(); chk("t4_ex_ready", ex_ready, 1);
        to_next(); ex_valid = 0; claim_valid = 1;
        to_neg(); chk("t4_retire_wren", gpr_wren, 1); chk("t4_claim_retire", claim_ready, 1);
        to_next();
        to_neg(); chk("t4_still_full", claim_ready, 0);
        to_next(); claim_valid = 0;
        for (int k = 0; k < 3; k++) begin
            ex_valid = 1;
            to_neg(); chk("t4_haz_b_pend", hazard_b, 1);
            to_next(); ex_valid = 0;
            to_neg();
            to_next();
        end
        to_neg(); chk("t4_haz_b_done", hazard_b, 0);
        to_next();

        // 5) clear sequence with MEM waiting
        clr_start = 1;
        busy_n = 0; wr_ok = 0; viol = 0; nxt = 1; granted = 0;
        for (int c = 0; c < 80 && !granted; c++) begin
            to_neg();
            if (clr_busy) busy_n++;
            if (clr_busy && mem_ready) viol++;
            if (gpr_wren && gpr_addr == nxt[4:0] && gpr_data == 0) begin
                wr_ok++; nxt++;
            end
            if (c > 0 && mem_ready && !clr_busy) granted = 1;
            to_next();
            clr_start = 0; mem_valid = 1; mem_addr = 4; mem_data = 32'hCAFE;
        end
        mem_valid = 0;
        chk("t5_busy_cycles", busy_n, 32);
        chk("t5_clear_writes", wr_ok, 31);
        chk("t5_mem_blocked", viol, 0);
        chk("t5_mem_granted", granted, 1);
        to_neg(); chk("t5_mem_write", gpr_addr, 4);
        to_next();

        // 6) reset in mid-clear, then an r0 write
        clr_start = 1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            to_neg();
            if (gpr_wren && gpr_addr == 11) found = 1;
            else begin
                to_next(); clr_start = 0;
            end
        end
        chk("t6_reached_idx12", found, 1);
        #1 rst = 1;
        #1;
        chk("t6_rst_wren", gpr_wren, 0);
        chk("t6_rst_addr", gpr_addr, 0);
        chk("t6_rst_busy", clr_busy, 0);
        to_next(); to_next(); rst = 0;
        ex_valid = 1; ex_addr = 0; ex_data = 32'h1234;
        to_neg(); chk("t6_r0_ready", ex_ready, 1); chk("t6_idle", clr_busy, 0);
        to_next(); ex_valid = 0;
        to_neg(); chk("t6_r0_wren", gpr_wren, 0);
        to_next();

        // Randomized traffic obeying the hold-until-ready handshake
        ex_go = 1; mem_go = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!ex_valid || ex_go) begin
                ex_valid = $urandom_range(0, 2) != 0;
                ex_addr  = 5'($urandom_range(0, 7));
                ex_data  = $urandom;
            end
            if (!mem_valid || mem_go) begin
                mem_valid = $urandom_range(0, 2) != 0;
                mem_addr  = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            claim_valid = $urandom_range(0, 2) == 0;
            claim_addr  = 5'($urandom_range(0, 7));
            rd_addr_a   = 5'($urandom_range(0, 7));
            rd_addr_b   = 5'($urandom_range(0, 7));
            clr_start   = $urandom_range(0, 99) == 0;
            to_neg();
            ex_go  = ex_valid && ex_ready;
            mem_go = mem_valid && mem_ready;
            to_next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
